nano_prog_loader: RTL and testbench

//  Boot-time program loader upstream of NanoCPU and its 256x16 memory. Receives a byte

---
 rtl/nano_prog_loader.sv | 154 +++++++++++++++
 tb/tb_nano_prog_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/nano_prog_loader.sv
// Boot-time program loader: turns a counted byte-stream frame into 16-bit memory writes
// while holding the CPU in reset, then hands the memory port over to the CPU bus.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// WAIT_CNT  | waiting for the word-count byte (no timeout)
// RX_HI     | waiting for the high byte of the next word
// RX_LO     | waiting for the low byte of the next word
// WRITE     | single-cycle memory write of the assembled word
// RELEASE   | CPU still in reset for RST_HOLD cycles after the load
// RUN       | CPU running, memory port is a pass-through of the CPU bus
// ERROR     | bad count or stream timeout; CPU held in reset until rst
module nano_prog_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int RST_HOLD  = 2,
    parameter int TIMEOUT   = 1000
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [15:0]       cpu_dataW,
    input  logic              cpu_ce,
    input  logic              cpu_we,
    output logic              cpu_rst,
    output logic [ADDR_W-1:0] mem_address,
    output logic [15:0]       mem_dataW,
    output logic              mem_ce,
    output logic              mem_we,
    output logic              load_done,
    output logic              load_err
);

    localparam int DEPTH     = 2 ** ADDR_W;
    localparam int MAX_WORDS = DEPTH - BASE_ADDR;
    localparam int TO_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD - 1);
    localparam logic [TO_W-1:0]   IDLE_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_WAIT_CNT,
        S_RX_HI,
        S_RX_LO,
        S_WRITE,
        S_RELEASE,
        S_RUN,
        S_ERROR
    } state_t;

    state_t            state, state_nxt;
    logic [7:0]        cnt;
    logic [7:0]        hi_byte;
    logic [7:0]        lo_byte;
    logic [ADDR_W:0]   ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TO_W-1:0]   idle_cnt;

    logic xfer;
    logic count_too_big;
    logic last_word;
    logic idle_expired;

    assign xfer          = in_valid & in_ready;
    assign count_too_big = {24'd0, in_data} > 32'(MAX_WORDS);
    assign last_word     = 32'(ptr) == (32'(cnt) - 32'd1);
    assign idle_expired  = (TIMEOUT != 0) && (idle_cnt == IDLE_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT_CNT: begin
                if (xfer) begin
                    if (in_data == 8'd0)    state_nxt = S_RELEASE;
                    else if (count_too_big) state_nxt = S_ERROR;
                    else                    state_nxt = S_RX_HI;
                end
            end
            S_RX_HI: begin
                if (xfer)              state_nxt = S_RX_LO;
                else if (idle_expired) state_nxt = S_ERROR;
            end
            S_RX_LO: begin
                if (xfer)              state_nxt = S_WRITE;
                else if (idle_expired) state_nxt = S_ERROR;
            end
            S_WRITE:   state_nxt = last_word ? S_RELEASE : S_RX_HI;
            S_RELEASE: if (hold_cnt == '0) state_nxt = S_RUN;
            S_RUN:     state_nxt = S_RUN;
            S_ERROR:   state_nxt = S_ERROR;
            default:   state_nxt = S_WAIT_CNT;
        endcase
    end

    // Memory port: loader drives it only in WRITE, the CPU owns it only in RUN.
    always_comb begin
        cpu_rst     = (state != S_RUN);
        load_done   = (state == S_RUN);
        load_err    = (state == S_ERROR);
        mem_ce      = 1'b0;
        mem_we      = 1'b0;
        mem_address = '0;
        mem_dataW   = '0;
        if (state == S_WRITE) begin
            mem_ce      = 1'b1;
            mem_we      = 1'b1;
            mem_address = ADDR_W'(BASE_ADDR) + ptr[ADDR_W-1:0];
            mem_dataW   = {hi_byte, lo_byte};
        end else if (state == S_RUN) begin
            mem_ce      = cpu_ce;
            mem_we      = cpu_we;
            mem_address = cpu_address;
            mem_dataW   = cpu_dataW;
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state    <= S_WAIT_CNT;
            in_ready <= 1'b0;
            cnt      <= '0;
            hi_byte  <= '0;
            lo_byte  <= '0;
            ptr      <= '0;
            hold_cnt <= HOLD_LOAD;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt == S_WAIT_CNT) || (state_nxt == S_RX_HI) ||
                        (state_nxt == S_RX_LO);

            if (state == S_WAIT_CNT && xfer) cnt     <= in_data;
            if (state == S_RX_HI && xfer)    hi_byte <= in_data;
            if (state == S_RX_LO && xfer)    lo_byte <= in_data;
            if (state == S_WRITE)            ptr     <= ptr + 1'b1;

            // Reloaded outside RELEASE so every entry path starts a full hold.
            if (state == S_RELEASE) begin
                if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
            end else begin
                hold_cnt <= HOLD_LOAD;
            end

            if ((state == S_RX_HI || state == S_RX_LO) && !xfer)
                idle_cnt <= idle_cnt + 1'b1;
            else
                idle_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_nano_prog_loader.sv
// Self-checking bench for nano_prog_loader: random frames and gaps, scoreboard of expected
// memory writes, release timing, timeout, CPU pass-through and mid-frame reset.
module tb_nano_prog_loader;

    localparam int ADDR_W    = 8;
    localparam int BASE_ADDR = 0;
    localparam int RST_HOLD  = 2;
    localparam int TIMEOUT   = 8;

    logic              ck = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        in_data = 8'd0;
    logic [ADDR_W-1:0] cpu_address = '0;
    logic [15:0]       cpu_dataW = '0;
    logic              cpu_ce = 1'b0;
    logic              cpu_we = 1'b0;
    logic              cpu_rst;
    logic [ADDR_W-1:0] mem_address;
    logic [15:0]       mem_dataW;
    logic              mem_ce;
    logic              mem_we;
    logic              load_done;
    logic              load_err;

    nano_prog_loader #(
        .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .RST_HOLD(RST_HOLD), .TIMEOUT(TIMEOUT)
    ) dut (
        .ck(ck), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cpu_address(cpu_address), .cpu_dataW(cpu_dataW), .cpu_ce(cpu_ce), .cpu_we(cpu_we),
        .cpu_rst(cpu_rst), .mem_address(mem_address), .mem_dataW(mem_dataW),
        .mem_ce(mem_ce), .mem_we(mem_we), .load_done(load_done), .load_err(load_err)
    );

    always #5 ck = ~ck;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    int          checks = 0;
    int          failures = 0;
    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [15:0] frame_w[$];
    bit          cpu_noise = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: any loader-side memory access must match the next expected write.
    always @(negedge ck) begin
        if (rst && !load_done && (mem_ce || mem_we)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_mem_access: actual addr=0x%0h data=0x%0h we=%0b required none",
                         mem_address, mem_dataW, mem_we);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(mem_address), 32'(mon_e.addr));
                check("wr_data", 32'(mem_dataW), 32'(mon_e.data));
                check("wr_ce_we", 32'({mem_ce, mem_we}), 32'h3);
            end
        end
    end

    // One clock step; the CPU bus is scrambled while the loader should be ignoring it.
    task automatic tick();
        @(posedge ck);
        #1;
        if (cpu_noise) begin
            cpu_address = ADDR_W'($urandom);
            cpu_dataW   = 16'($urandom);
            cpu_ce      = 1'($urandom);
            cpu_we      = 1'($urandom);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        bit acc = 1'b0;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = b;
        while (!acc && n < 50) begin
            @(negedge ck);
            acc = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL byte_accept: byte 0x%0h actual not accepted within 50 cycles required accepted", b);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge ck);
        check("rst_flags{cpu_rst,in_ready,ce,we,done,err}",
              32'({cpu_rst, in_ready, mem_ce, mem_we, load_done, load_err}), 32'h20);
        check("rst_mem_address", 32'(mem_address), 0);
        check("rst_mem_dataW", 32'(mem_dataW), 0);
        tick();
        rst = 1'b1;
    endtask

    function automatic int pick_gap(input int max_gap);
        return (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
    endfunction

    // Sends frame_w as one frame and checks the release timing: after the last byte the
    // CPU stays in reset for the WRITE cycle (if any) plus RST_HOLD cycles.
    task automatic run_frame(input int max_gap);
        int n = frame_w.size();
        int hold_cycles;
        send_byte(8'(n), pick_gap(max_gap));
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{addr: ADDR_W'(BASE_ADDR + i), data: frame_w[i]});
            send_byte(frame_w[i][15:8], pick_gap(max_gap));
            send_byte(frame_w[i][7:0], pick_gap(max_gap));
        end
        hold_cycles = (n > 0) ? RST_HOLD + 1 : RST_HOLD;
        for (int c = 0; c < hold_cycles; c++) begin
            @(negedge ck);
            check("cpu_rst_held", 32'({cpu_rst, load_done}), 32'h2);
        end
        @(negedge ck);
        check("run_flags{cpu_rst,done,err,in_ready}",
              32'({cpu_rst, load_done, load_err, in_ready}), 32'h4);
        check("writes_outstanding", 32'(exp_q.size()), 0);
    endtask

    task automatic check_passthrough(input int iters);
        cpu_noise = 1'b0;
        for (int i = 0; i < iters; i++) begin
            if (i == 0) begin
                cpu_address = ADDR_W'(8'h0A);
                cpu_dataW   = 16'h002D;
                cpu_ce      = 1'b1;
                cpu_we      = 1'b1;
            end else begin
                cpu_address = ADDR_W'($urandom);
                cpu_dataW   = 16'($urandom);
                cpu_ce      = 1'($urandom);
                cpu_we      = 1'($urandom);
            end
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            #1;
            check("pass_addr", 32'(mem_address), 32'(cpu_address));
            check("pass_data", 32'(mem_dataW), 32'(cpu_dataW));
            check("pass_ce_we", 32'({mem_ce, mem_we}), 32'({cpu_ce, cpu_we}));
            check("run_in_ready", 32'(in_ready), 0);
            tick();
        end
        in_valid  = 1'b0;
        cpu_noise = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual still running required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Directed three-word frame, in_valid held high.
        do_reset();
        frame_w = '{16'h4000, 16'h4111, 16'h0093};
        run_frame(0);
        check_passthrough(6);

        // Empty frame: straight to release, no writes.
        do_reset();
        frame_w.delete();
        run_frame(0);

        // Two words with random gaps below the timeout.
        do_reset();
        frame_w = '{16'($urandom), 16'($urandom)};
        run_frame(5);

        for (int f = 0; f < 5; f++) begin
            int n = int'($urandom_range(0, 6));
            do_reset();
            frame_w.delete();
            for (int i = 0; i < n; i++) frame_w.push_back(16'($urandom));
            run_frame(5);
            check_passthrough(2);
        end

        // Timeout in the middle of a word.
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        repeat (TIMEOUT) @(negedge ck);
        check("err_before_timeout", 32'(load_err), 0);
        @(negedge ck);
        check("timeout_flags{err,cpu_rst,done,in_ready,we}",
              32'({load_err, cpu_rst, load_done, in_ready, mem_we}), 32'h18);
        tick();
        in_valid = 1'b1;
        in_data  = 8'h34;
        repeat (5) tick();
        @(negedge ck);
        check("error_sticky{err,cpu_rst,in_ready}", 32'({load_err, cpu_rst, in_ready}), 32'h6);
        tick();
        in_valid = 1'b0;

        // Reset right after the third byte, then a fresh frame.
        do_reset();
        send_byte(8'h02, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        do_reset();
        frame_w = '{16'hF000};
        run_frame(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
